// File: rtl/pipe_hazard_tracker.sv
// Read-after-write hazard tracker for a short in-order pipeline.
// Tracks destination registers of in-flight instructions and flags dependent reads and PC writes.
module pipe_hazard_tracker #(
  parameter int DEPTH      = 3,
  parameter int WPORTS     = 2,
  parameter int RPORTS     = 2,
  parameter int AW         = 5,
  parameter int COND_STAGE = 0,
  parameter int RWB_HAZARD = 1,
  parameter logic [AW-1:0] PC_ADDR = 5'd31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [WPORTS*AW-1:0] iss_wa,
  input  logic [WPORTS-1:0]    iss_wen,
  input  logic [RPORTS*AW-1:0] rd_a,
  input  logic [RPORTS-1:0]    rd_en,
  input  logic                 cond_res,
  input  logic                 flush,
  output logic [RPORTS-1:0]    hz_port,
  output logic                 stall,
  output logic                 jmp_hazard,
  output logic [3:0]           occupancy,
  output logic [15:0]          stall_cnt
);

  logic [DEPTH-1:0]     slot_vld;
  logic [WPORTS-1:0]    slot_wen [DEPTH];
  logic [WPORTS*AW-1:0] slot_wa  [DEPTH];

  logic [DEPTH-1:0]     nxt_vld;
  logic [WPORTS-1:0]    nxt_wen [DEPTH];
  logic [WPORTS*AW-1:0] nxt_wa  [DEPTH];

  logic accept;
  logic cnt_inc;

  function automatic logic [3:0] count_vld(input logic [DEPTH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Hazard detection over the current slot contents
  always_comb begin
    hz_port    = '0;
    jmp_hazard = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int k = 0; k < WPORTS; k++) begin
        if (slot_vld[s] && slot_wen[s][k]) begin
          if (slot_wa[s][k*AW +: AW] == PC_ADDR) jmp_hazard = 1'b1;
          if (s < DEPTH-1 || RWB_HAZARD != 0) begin
            for (int p = 0; p < RPORTS; p++) begin
              if (rd_en[p] && slot_wa[s][k*AW +: AW] == rd_a[p*AW +: AW])
                hz_port[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall   = (|hz_port) | jmp_hazard;
  assign accept  = iss_valid & ~stall & ~flush;
  assign cnt_inc = iss_valid & stall & ~flush;

  // Next slot contents: issue into slot 0, shift the rest, apply cancel and flush
  always_comb begin
    nxt_vld[0] = accept;
    nxt_wen[0] = accept ? iss_wen : '0;
    nxt_wa[0]  = iss_wa;
    for (int s = 1; s < DEPTH; s++) begin
      nxt_vld[s] = slot_vld[s-1];
      nxt_wen[s] = slot_wen[s-1];
      nxt_wa[s]  = slot_wa[s-1];
      // A failed condition keeps the slot occupied but kills its writes
      if (s - 1 == COND_STAGE && !cond_res) nxt_wen[s] = '0;
      if (flush && s - 1 <= COND_STAGE) begin
        nxt_vld[s] = 1'b0;
        nxt_wen[s] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld  <= '0;
      for (int s = 0; s < DEPTH; s++) slot_wen[s] <= '0;
      occupancy <= '0;
      stall_cnt <= '0;
    end else begin
      slot_vld  <= nxt_vld;
      for (int s = 0; s < DEPTH; s++) slot_wen[s] <= nxt_wen[s];
      occupancy <= count_vld(nxt_vld);
      if (cnt_inc) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) slot_wa[s] <= nxt_wa[s];
  end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed bench for pipe_hazard_tracker: default build, build without write-back
// matching, and an 8-deep build used for the stall counter saturation run.
module tb_pipe_hazard_tracker;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [9:0]  iss_wa;
  logic [1:0]  iss_wen;
  logic [9:0]  rd_a;
  logic [1:0]  rd_en;
  logic        cond_res;
  logic        flush;

  logic [1:0]  hz_a, hz_b, hz_c;
  logic        st_a, st_b, st_c;
  logic        jh_a, jh_b, jh_c;
  logic [3:0]  oc_a, oc_b, oc_c;
  logic [15:0] sc_a, sc_b, sc_c;

  int vectors = 0;
  int miscompares = 0;

  pipe_hazard_tracker dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_wen(iss_wen),
    .rd_a(rd_a), .rd_en(rd_en), .cond_res(cond_res), .flush(flush),
    .hz_port(hz_a), .stall(st_a), .jmp_hazard(jh_a), .occupancy(oc_a), .stall_cnt(sc_a)
  );

  pipe_hazard_tracker #(.RWB_HAZARD(0)) dut_nwb (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_wen(iss_wen),
    .rd_a(rd_a), .rd_en(rd_en), .cond_res(cond_res), .flush(flush),
    .hz_port(hz_b), .stall(st_b), .jmp_hazard(jh_b), .occupancy(oc_b), .stall_cnt(sc_b)
  );

  pipe_hazard_tracker #(.DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_wen(iss_wen),
    .rd_a(rd_a), .rd_en(rd_en), .cond_res(cond_res), .flush(flush),
    .hz_port(hz_c), .stall(st_c), .jmp_hazard(jh_c), .occupancy(oc_c), .stall_cnt(sc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_wa    = '0;
    iss_wen   = '0;
    rd_a      = '0;
    rd_en     = '0;
    cond_res  = 1'b1;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_occ", 32'(oc_a), 32'd0);
    chk("rst_scnt", 32'(sc_a), 32'd0);
    chk("rst_stall", 32'(st_a), 32'd0);
    chk("rst_hz", 32'(hz_a), 32'd0);
    chk("rst_jmp", 32'(jh_a), 32'd0);

    // RAW on r3: three stall cycles, two without write-back matching
    iss_valid = 1'b1; iss_wa = {5'd0, 5'd3}; iss_wen = 2'b01;
    #1;
    chk("A_issue_stall", 32'(st_a), 32'd0);
    tick();
    chk("A_occ1", 32'(oc_a), 32'd1);
    iss_wa = {5'd0, 5'd7}; rd_a = {5'd0, 5'd3}; rd_en = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("A_hz", 32'(hz_a), (i < 3) ? 32'd1 : 32'd0);
      chk("A_stall", 32'(st_a), (i < 3) ? 32'd1 : 32'd0);
      chk("A_hz_nwb", 32'(hz_b), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("A_scnt", 32'(sc_a), 32'd3);
    chk("A_scnt_nwb", 32'(sc_b), 32'd2);
    chk("A_occ_reader", 32'(oc_a), 32'd1);

    // Condition failure cancels the write but keeps the slot
    do_reset();
    iss_valid = 1'b1; iss_wa = {5'd0, 5'd4}; iss_wen = 2'b01;
    tick();
    iss_valid = 1'b0; cond_res = 1'b0; rd_a = {5'd4, 5'd0}; rd_en = 2'b10;
    #1;
    chk("B_hz_conservative", 32'(hz_a), 32'd2);
    tick();
    cond_res = 1'b1;
    #1;
    chk("B_hz_cancelled", 32'(hz_a), 32'd0);
    chk("B_stall", 32'(st_a), 32'd0);
    chk("B_occ", 32'(oc_a), 32'd1);

    // PC write on port 1
    do_reset();
    iss_valid = 1'b1; iss_wa = {5'd31, 5'd2}; iss_wen = 2'b10;
    #1;
    chk("C_jmp_pre", 32'(jh_a), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("C_jmp", 32'(jh_a), (i < 3) ? 32'd1 : 32'd0);
      chk("C_stall", 32'(st_a), (i < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("C_scnt", 32'(sc_a), 32'd3);
    chk("C_occ", 32'(oc_a), 32'd1);

    // Fill, collision match, then flush
    do_reset();
    iss_valid = 1'b1; iss_wa = {5'd3, 5'd3}; iss_wen = 2'b11;
    tick();
    iss_wa = {5'd0, 5'd9}; iss_wen = 2'b01;
    tick();
    iss_wa = {5'd0, 5'd10};
    tick();
    chk("D_occ_full", 32'(oc_a), 32'd3);
    iss_valid = 1'b0; rd_a = {5'd9, 5'd3}; rd_en = 2'b11;
    #1;
    chk("D_hz_both", 32'(hz_a), 32'd3);
    rd_en = 2'b00; iss_valid = 1'b1; iss_wa = {5'd0, 5'd12}; iss_wen = 2'b01; flush = 1'b1;
    #1;
    chk("D_flush_stall", 32'(st_a), 32'd0);
    tick();
    chk("D_occ_flush", 32'(oc_a), 32'd1);
    flush = 1'b0; iss_valid = 1'b0; rd_a = {5'd9, 5'd12}; rd_en = 2'b11;
    #1;
    chk("D_hz_survivor", 32'(hz_a), 32'd2);
    rd_a = {5'd10, 5'd12};
    #1;
    chk("D_hz_flushed", 32'(hz_a), 32'd0);
    iss_valid = 1'b1; iss_wa = {5'd0, 5'd14}; flush = 1'b1; rd_a = {5'd9, 5'd0}; rd_en = 2'b10;
    #1;
    chk("D_stall_in_flush", 32'(st_a), 32'd1);
    tick();
    chk("D_scnt_flush", 32'(sc_a), 32'd0);
    chk("D_occ_empty", 32'(oc_a), 32'd0);

    // Recurring self-dependency drives the counter into saturation
    do_reset();
    iss_valid = 1'b1; iss_wa = {5'd0, 5'd5}; iss_wen = 2'b01;
    rd_a = {5'd0, 5'd5}; rd_en = 2'b01;
    repeat (73800) tick();
    chk("E_scnt_sat", 32'(sc_c), 32'hFFFF);
    repeat (40) tick();
    chk("E_scnt_hold", 32'(sc_c), 32'hFFFF);
    #1;
    chk("E_stall_pre_rst", 32'(st_c), 32'd1);
    chk("E_hz_pre_rst", 32'(hz_c), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("E_rst_hz", 32'(hz_c), 32'd0);
    chk("E_rst_stall", 32'(st_c), 32'd0);
    chk("E_rst_jmp", 32'(jh_c), 32'd0);
    chk("E_rst_occ", 32'(oc_c), 32'd0);
    chk("E_rst_scnt", 32'(sc_c), 32'd0);
    chk("E_rst_scnt_def", 32'(sc_a), 32'd0);
    rst = 1'b0;
    #1;
    chk("E_post_rst_stall", 32'(st_c), 32'd0);
    tick();
    chk("E_post_rst_occ", 32'(oc_c), 32'd1);
    chk("E_post_rst_scnt", 32'(sc_c), 32'd0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
